// File: rtl/instr_stream_loader.sv
// Byte-serial program loader: frames the stream with FE/FF markers, packs bytes
// MSB-first into 32-bit words, writes them to instruction memory, then releases the CPU.
module instr_stream_loader #(
    parameter int IMEM_DEPTH = 64,
    parameter int AW         = 6
) (
    input  logic          clk_i,
    input  logic          reset,
    input  logic          instr_valid_i,
    input  logic [7:0]    instr_i,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_addr_o,
    output logic [31:0]   imem_wdata_o,
    output logic [AW:0]   word_count_o,
    output logic          cpu_start_o,
    output logic          cpu_run_o,
    output logic          overflow_o
);
    localparam logic [7:0]  START_MARK = 8'hFE;
    localparam logic [7:0]  END_MARK   = 8'hFF;
    localparam logic [AW:0] DEPTH_C    = (AW+1)'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_byte_cnt, w_byte_cnt_nxt;
    logic [23:0]   r_word_buf, w_word_buf_nxt;
    logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [AW:0]   r_word_count, w_word_count_nxt;
    logic          r_we, w_we_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [31:0]   r_wdata, w_wdata_nxt;
    logic          r_start, w_start_nxt;
    logic          r_run, w_run_nxt;
    logic          r_overflow, w_overflow_nxt;

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= 2'd0;
            r_word_buf   <= 24'd0;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_start      <= 1'b0;
            r_run        <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_word_buf   <= w_word_buf_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_word_count <= w_word_count_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_start      <= w_start_nxt;
            r_run        <= w_run_nxt;
            r_overflow   <= w_overflow_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_word_buf_nxt   = r_word_buf;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_word_count_nxt = r_word_count;
        w_we_nxt         = 1'b0;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_start_nxt      = 1'b0;
        w_run_nxt        = r_run;
        w_overflow_nxt   = r_overflow;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid_i && (instr_i == START_MARK)) begin
                    w_state_nxt      = ST_LOAD;
                    w_byte_cnt_nxt   = 2'd0;
                    w_wr_ptr_nxt     = '0;
                    w_word_count_nxt = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!instr_valid_i) begin
                    w_state_nxt = ST_LOAD;
                end else if ((r_byte_cnt == 2'd0) && (instr_i == END_MARK)) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    // Earlier bytes shift up so the first byte lands in [31:24].
                    if (r_byte_cnt != 2'd3) begin
                        w_word_buf_nxt = {r_word_buf[15:0], instr_i};
                    end else if (r_word_count == DEPTH_C) begin
                        w_overflow_nxt = 1'b1;
                    end else begin
                        w_we_nxt         = 1'b1;
                        w_addr_nxt       = r_wr_ptr;
                        w_wdata_nxt      = {r_word_buf, instr_i};
                        w_wr_ptr_nxt     = r_wr_ptr + AW'(1'b1);
                        w_word_count_nxt = r_word_count + (AW+1)'(1'b1);
                    end
                end
            end
            ST_START: begin
                w_state_nxt = ST_RUN;
                w_start_nxt = 1'b1;
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
                w_run_nxt   = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imem_we_o    = r_we;
    assign imem_addr_o  = r_addr;
    assign imem_wdata_o = r_wdata;
    assign word_count_o = r_word_count;
    assign cpu_start_o  = r_start;
    assign cpu_run_o    = r_run;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Self-checking bench for instr_stream_loader: directed vector table, hand-written
// timing/reset sequences, and randomized streams checked against a stream-level model.
module tb_instr_stream_loader;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk_i = 1'b0;
    logic          reset = 1'b1;
    logic          instr_valid_i = 1'b0;
    logic [7:0]    instr_i = 8'h00;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_wdata_o;
    logic [AW:0]   word_count_o;
    logic          cpu_start_o;
    logic          cpu_run_o;
    logic          overflow_o;

    instr_stream_loader #(.IMEM_DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i         (clk_i),
        .reset         (reset),
        .instr_valid_i (instr_valid_i),
        .instr_i       (instr_i),
        .imem_we_o     (imem_we_o),
        .imem_addr_o   (imem_addr_o),
        .imem_wdata_o  (imem_wdata_o),
        .word_count_o  (word_count_o),
        .cpu_start_o   (cpu_start_o),
        .cpu_run_o     (cpu_run_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    int            n_starts = 0;
    logic [7:0]    sent[$];

    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    int            exp_cnt;
    bit            exp_ovf;
    int            exp_starts;
    bit            exp_run;

    typedef struct {
        string        name;
        logic [127:0] seq;
        int           len;
        int           nwr;
        logic [31:0]  w0;
        int           cnt;
        bit           run;
    } vec_t;
    vec_t vecs[6];

    // Write/start monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (imem_we_o) begin
            got_addr.push_back(imem_addr_o);
            got_data.push_back(imem_wdata_o);
        end
        if (cpu_start_o) n_starts++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit v, input logic [7:0] b);
        @(negedge clk_i);
        reset = 1'b1;
        instr_valid_i = v;
        instr_i = b;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        check("reset_outputs", {imem_we_o, imem_addr_o, imem_wdata_o, word_count_o,
                                cpu_start_o, cpu_run_o, overflow_o}, 64'd0);
        got_addr.delete();
        got_data.delete();
        n_starts = 0;
        sent.delete();
        @(negedge clk_i);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk_i);
            instr_valid_i = 1'b0;
        end
        @(negedge clk_i);
        instr_valid_i = 1'b1;
        instr_i = b;
        sent.push_back(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            instr_valid_i = 1'b0;
        end
    endtask

    // Reference: walk the accepted byte list and apply the framing rules directly.
    task automatic model();
        bit         loading;
        logic [7:0] cur[$];
        logic [7:0] b;
        loading = 1'b0;
        exp_run = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        exp_starts = 0;
        foreach (sent[i]) begin
            b = sent[i];
            if (exp_run) continue;
            if (!loading) begin
                if (b == 8'hFE) begin
                    loading = 1'b1;
                    exp_cnt = 0;
                    cur.delete();
                end
            end else if (cur.size() == 0 && b == 8'hFF) begin
                exp_run = 1'b1;
                exp_starts = 1;
            end else begin
                cur.push_back(b);
                if (cur.size() == 4) begin
                    if (exp_cnt < DEPTH) begin
                        exp_addr.push_back(AW'(exp_cnt));
                        exp_data.push_back({cur[0], cur[1], cur[2], cur[3]});
                        exp_cnt++;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                    cur.delete();
                end
            end
        end
    endtask

    task automatic compare_model(input string name);
        model();
        check({name, "_nwrites"}, 64'(got_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check({name, "_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
            check({name, "_data"}, 64'(got_data[i]), 64'(exp_data[i]));
        end
        check({name, "_word_count"}, 64'(word_count_o), 64'(exp_cnt));
        check({name, "_overflow"}, 64'(overflow_o), 64'(exp_ovf));
        check({name, "_starts"}, 64'(n_starts), 64'(exp_starts));
        check({name, "_run"}, 64'(cpu_run_o), 64'(exp_run));
    endtask

    initial begin
        logic [127:0] seq;
        int           nw;
        vecs[0] = '{"basic",   {8'hFE, 32'h12345678, 32'h9ABCDEF0, 8'hFF, 48'h0}, 10, 2, 32'h12345678, 2, 1'b1};
        vecs[1] = '{"mark_dat", {8'hFE, 32'h00FFFEFF, 8'hFF, 80'h0},              6, 1, 32'h00FFFEFF, 1, 1'b1};
        vecs[2] = '{"idle_flt", {24'h00FF3C, 8'hFE, 32'h01020304, 8'hFF, 56'h0},  9, 1, 32'h01020304, 1, 1'b1};
        vecs[3] = '{"no_end",   {8'hFE, 40'hA1B2C3D4E5, 80'h0},                   6, 1, 32'hA1B2C3D4, 1, 1'b0};
        vecs[4] = '{"run_lock", {8'hFE, 32'h11223344, 8'hFF, 8'hFE, 32'h55667788, 8'hFF, 32'h0},
                    12, 1, 32'h11223344, 1, 1'b1};
        vecs[5] = '{"empty",    {8'hFE, 8'hFF, 112'h0},                           2, 0, 32'h0, 0, 1'b1};

        for (int v = 0; v < 6; v++) begin
            do_reset(1'b0, 8'h00);
            seq = vecs[v].seq;
            for (int i = 0; i < vecs[v].len; i++) send_byte(seq[127-8*i -: 8], 0);
            idle(5);
            check({vecs[v].name, "_tbl_nwr"}, 64'(got_data.size()), 64'(vecs[v].nwr));
            if (got_data.size() > 0) begin
                check({vecs[v].name, "_tbl_w0"}, 64'(got_data[0]), 64'(vecs[v].w0));
                check({vecs[v].name, "_tbl_a0"}, 64'(got_addr[0]), 64'd0);
            end
            check({vecs[v].name, "_tbl_cnt"}, 64'(word_count_o), 64'(vecs[v].cnt));
            check({vecs[v].name, "_tbl_run"}, 64'(cpu_run_o), 64'(vecs[v].run));
            check({vecs[v].name, "_tbl_starts"}, 64'(n_starts), 64'(vecs[v].run));
            compare_model(vecs[v].name);
        end

        // Write latency, gap freeze and end-marker latency.
        do_reset(1'b0, 8'h00);
        send_byte(8'hFE, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 3);
        send_byte(8'h03, 3);
        send_byte(8'h04, 0);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        check("lat_we", 64'(imem_we_o), 64'd1);
        check("lat_addr", 64'(imem_addr_o), 64'd0);
        check("lat_data", 64'(imem_wdata_o), 64'h01020304);
        check("lat_cnt", 64'(word_count_o), 64'd1);
        @(negedge clk_i);
        check("hold_we", 64'(imem_we_o), 64'd0);
        check("hold_data", 64'(imem_wdata_o), 64'h01020304);
        send_byte(8'hFF, 0);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        check("end_n0", {cpu_start_o, cpu_run_o}, 64'd0);
        @(negedge clk_i);
        check("end_n1", {cpu_start_o, cpu_run_o}, 64'b10);
        @(negedge clk_i);
        check("end_n2", {cpu_start_o, cpu_run_o}, 64'b01);
        idle(3);
        compare_model("gap_load");

        // Reset while in START: the start pulse must never appear.
        do_reset(1'b0, 8'h00);
        send_byte(8'hFE, 0);
        send_byte(8'hFF, 0);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        reset = 1'b1;
        @(negedge clk_i);
        check("rst_in_start", {cpu_start_o, cpu_run_o}, 64'd0);
        check("rst_in_start_pulses", 64'(n_starts), 64'd0);

        // Reset mid-word of word 3, with a simultaneous FE that must be dropped.
        do_reset(1'b0, 8'h00);
        send_byte(8'hFE, 0);
        for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i), 0);
        do_reset(1'b1, 8'hFE);
        foreach (vecs[4].seq[i]) begin end
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'hFF, 0);
        idle(4);
        check("rst_drop_nwr", 64'(got_data.size()), 64'd0);
        compare_model("rst_drop");
        do_reset(1'b0, 8'h00);
        send_byte(8'hFE, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        send_byte(8'hFF, 0);
        idle(4);
        check("rst_reload_nwr", 64'(got_data.size()), 64'd1);
        if (got_data.size() > 0) check("rst_reload_w0", 64'(got_data[0]), 64'hAABBCCDD);
        compare_model("rst_reload");

        // Overflow: 65 words into a 64-word memory.
        do_reset(1'b0, 8'h00);
        send_byte(8'hFE, 0);
        for (int w = 0; w < 65; w++) begin
            send_byte(8'($urandom_range(0, 254)), 0);
            for (int k = 1; k < 4; k++) send_byte(8'($urandom_range(0, 255)), 0);
        end
        send_byte(8'hFF, 0);
        idle(4);
        check("ovf_nwr", 64'(got_data.size()), 64'd64);
        check("ovf_flag", 64'(overflow_o), 64'd1);
        check("ovf_cnt", 64'(word_count_o), 64'd64);
        check("ovf_starts", 64'(n_starts), 64'd1);
        compare_model("overflow");

        // Randomized streams.
        for (int it = 0; it < 25; it++) begin
            do_reset(1'b0, 8'h00);
            repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 255)), 0);
            send_byte(8'hFE, 0);
            nw = int'($urandom_range(0, 6));
            for (int w = 0; w < nw; w++) begin
                for (int k = 0; k < 4; k++) begin
                    send_byte((k == 0 && $urandom_range(0, 9) != 0) ? 8'($urandom_range(0, 254))
                                                                     : 8'($urandom_range(0, 255)),
                              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
                end
            end
            if ($urandom_range(0, 4) != 0) send_byte(8'hFF, int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 4)) send_byte(8'($urandom_range(0, 255)), 0);
            idle(4);
            compare_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
